// File: rtl/fp_pkg.sv
// Shared constants and FSM state type for the fp_accum half-precision accumulator.
package fp_pkg;

  localparam int unsigned DefExponentWidth = 5;
  localparam int unsigned DefMantissaWidth = 10;
  localparam int unsigned Bias             = 2 ** (DefExponentWidth - 1) - 1;
  localparam int unsigned MaxFiniteExp     = 2 ** DefExponentWidth - 2;

  typedef enum logic [2:0] {
    StIdle,
    StAccept,
    StAlign,
    StAdd,
    StNorm,
    StOut
  } state_e;

  // Largest biased exponent that still encodes a finite value.
  function automatic int unsigned max_finite_exp(input int unsigned ew);
    return 2 ** ew - 2;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports Width.
module fp_lzc #(
  parameter int unsigned Width = 13,
  parameter int unsigned CntW  = $clog2(Width + 1)
) (
  input  logic [Width-1:0] value_i,
  output logic [CntW-1:0]  count_o
);

  always_comb begin
    count_o = CntW'(Width);
    for (int i = 0; i < Width; i++) begin
      if (value_i[i]) count_o = CntW'(Width - 1 - i);
    end
  end

endmodule

// File: rtl/fp_accum.sv
// Half-precision accumulator: sums ACC_LEN unpacked products, one in flight at a time.
// Optional FP_ACCUM_RELU_EN clamps negative final sums to +0.
module fp_accum
  import fp_pkg::*;
#(
  parameter int unsigned EXPONENT_WIDTH = DefExponentWidth,
  parameter int unsigned MANTISSA_WIDTH = DefMantissaWidth,
  parameter int unsigned ACC_LEN        = 9
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic                                    in_sign,
  input  logic [EXPONENT_WIDTH-1:0]               in_exponent,
  input  logic [MANTISSA_WIDTH-1:0]               in_prod,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]  out_sum
);

  localparam int unsigned ManW = MANTISSA_WIDTH + 3;
  localparam int unsigned ExpW = EXPONENT_WIDTH + 1;
  localparam int unsigned LzW  = $clog2(ManW + 1);
  localparam int unsigned CntW = $clog2(ACC_LEN + 1);
  localparam int unsigned SumW = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;
  localparam logic [ExpW-1:0] SatExp  = ExpW'(max_finite_exp(EXPONENT_WIDTH));
  localparam logic [ExpW:0]   OvfExp  = (ExpW + 1)'(2 ** EXPONENT_WIDTH - 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(ACC_LEN);

  state_e state_q, state_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [SumW-1:0] out_sum_q, out_sum_d;
  logic [CntW-1:0] cnt_q;
  logic            acc_sign_q, sat_q, op_sign_q, big_sign_q, sml_sign_q, sum_sign_q;
  logic [ExpW-1:0] acc_exp_q, op_exp_q, big_exp_q, sum_exp_q;
  logic [ManW-1:0] acc_man_q, op_man_q, big_man_q, sml_man_q;
  logic [ManW:0]   sum_q;
  logic            in_fire;

  assign in_fire   = in_valid && in_ready_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   state_d = StAccept;
      StAccept: if (in_fire) state_d = StAlign;
      StAlign:  state_d = StAdd;
      StAdd:    state_d = StNorm;
      StNorm:   state_d = (cnt_q == LastCnt) ? StOut : StAccept;
      StOut:    if (out_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready_d  = (state_d == StAccept);
    out_valid_d = (state_d == StOut);
  end

  // Align: the operand with the smaller exponent is shifted toward the larger one.
  logic            acc_big;
  logic [ExpW-1:0] exp_diff;
  logic [ManW-1:0] sml_raw, sml_aligned;
  always_comb begin
    acc_big     = acc_exp_q >= op_exp_q;
    exp_diff    = acc_big ? acc_exp_q - op_exp_q : op_exp_q - acc_exp_q;
    sml_raw     = acc_big ? op_man_q : acc_man_q;
    sml_aligned = (exp_diff > ExpW'(ManW - 1)) ? '0 : sml_raw >> exp_diff;
  end

  logic          add_sign;
  logic [ManW:0] add_sum;
  always_comb begin
    if (big_sign_q == sml_sign_q) begin
      add_sum  = {1'b0, big_man_q} + {1'b0, sml_man_q};
      add_sign = big_sign_q;
    end else if (big_man_q >= sml_man_q) begin
      add_sum  = {1'b0, big_man_q - sml_man_q};
      add_sign = big_sign_q;
    end else begin
      add_sum  = {1'b0, sml_man_q - big_man_q};
      add_sign = sml_sign_q;
    end
  end

  logic [LzW-1:0]  lz;
  logic [ExpW:0]   norm_exp;
  logic [ManW-1:0] norm_man, new_man;
  logic [ExpW-1:0] new_exp;
  logic            new_sign, new_sat;

  fp_lzc #(
    .Width(ManW),
    .CntW (LzW)
  ) u_lzc (
    .value_i(sum_q[ManW-1:0]),
    .count_o(lz)
  );

  // norm_exp is two's complement one bit wider than the accumulator exponent.
  always_comb begin
    if (sum_q[ManW]) begin
      norm_man = sum_q[ManW:1];
      norm_exp = {1'b0, sum_exp_q} + (ExpW + 1)'(1);
    end else begin
      norm_man = sum_q[ManW-1:0] << lz;
      norm_exp = {1'b0, sum_exp_q} - (ExpW + 1)'(lz);
    end
    new_sign = sum_sign_q;
    new_exp  = norm_exp[ExpW-1:0];
    new_man  = norm_man;
    new_sat  = sat_q;
    if (sat_q) begin
      new_sign = acc_sign_q;
      new_exp  = acc_exp_q;
      new_man  = acc_man_q;
    end else if (sum_q == '0 || norm_exp[ExpW] || norm_exp == '0) begin
      new_sign = 1'b0;
      new_exp  = '0;
      new_man  = '0;
    end else if (norm_exp >= OvfExp) begin
      new_exp  = SatExp;
      new_man  = '1;
      new_sat  = 1'b1;
    end
    out_sum_d = {new_sign, new_exp[EXPONENT_WIDTH-1:0], new_man[ManW-2:2]};
`ifdef FP_ACCUM_RELU_EN
    if (new_sign) out_sum_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      cnt_q       <= '0;
      acc_sign_q  <= 1'b0;
      acc_exp_q   <= '0;
      acc_man_q   <= '0;
      sat_q       <= 1'b0;
      op_sign_q   <= 1'b0;
      op_exp_q    <= '0;
      op_man_q    <= '0;
      big_sign_q  <= 1'b0;
      big_exp_q   <= '0;
      big_man_q   <= '0;
      sml_sign_q  <= 1'b0;
      sml_man_q   <= '0;
      sum_sign_q  <= 1'b0;
      sum_exp_q   <= '0;
      sum_q       <= '0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      unique case (state_q)
        StIdle: begin
          cnt_q      <= '0;
          acc_sign_q <= 1'b0;
          acc_exp_q  <= '0;
          acc_man_q  <= '0;
          sat_q      <= 1'b0;
        end
        StAccept: begin
          if (in_fire) begin
            cnt_q     <= cnt_q + CntW'(1);
            op_sign_q <= in_sign;
            // A zero exponent means zero regardless of the mantissa bits.
            if (in_exponent == '0) begin
              op_exp_q <= '0;
              op_man_q <= '0;
            end else begin
              op_exp_q <= {1'b0, in_exponent};
              op_man_q <= {1'b1, in_prod, 2'b00};
            end
          end
        end
        StAlign: begin
          big_sign_q <= acc_big ? acc_sign_q : op_sign_q;
          big_exp_q  <= acc_big ? acc_exp_q : op_exp_q;
          big_man_q  <= acc_big ? acc_man_q : op_man_q;
          sml_sign_q <= acc_big ? op_sign_q : acc_sign_q;
          sml_man_q  <= sml_aligned;
        end
        StAdd: begin
          sum_q      <= add_sum;
          sum_sign_q <= add_sign;
          sum_exp_q  <= big_exp_q;
        end
        StNorm: begin
          acc_sign_q <= new_sign;
          acc_exp_q  <= new_exp;
          acc_man_q  <= new_man;
          sat_q      <= new_sat;
          if (cnt_q == LastCnt) out_sum_q <= out_sum_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accum.sv
// Directed and randomized bench for fp_accum with ACC_LEN = 4.
module tb_fp_accum;

  localparam int unsigned AccLen = 4;
`ifdef FP_ACCUM_RELU_EN
  localparam bit Relu = 1'b1;
`else
  localparam bit Relu = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_word = '0;
  logic        in_ready, out_valid;
  logic [15:0] out_sum;
  logic        in_sign;
  logic [4:0]  in_exponent;
  logic [9:0]  in_prod;

  int tests = 0;
  int failed = 0;

  assign in_sign     = in_word[15];
  assign in_exponent = in_word[14:10];
  assign in_prod     = in_word[9:0];

  always #5 clk = ~clk;

  fp_accum #(
    .EXPONENT_WIDTH(5),
    .MANTISSA_WIDTH(10),
    .ACC_LEN       (AccLen)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exponent(in_exponent),
    .in_prod    (in_prod),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // Exact half-precision encoding of n/8; valid while |n| <= 1023.
  function automatic logic [15:0] enc(input int n);
    int mag, p, e, frac;
    logic s;
    if (n == 0) return 16'h0000;
    s   = (n < 0);
    mag = s ? -n : n;
    p   = 0;
    for (int i = 0; i < 16; i++) if ((mag >> i) != 0) p = i;
    e    = p - 3 + 15;
    frac = (mag << (10 - p)) & 'h3FF;
    return {s, e[4:0], frac[9:0]};
  endfunction

  task automatic send(input logic [15:0] w);
    int n;
    in_valid = 1'b1;
    in_word  = w;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_word  = 16'($urandom);
  endtask

  task automatic run_window(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d,
                            input logic [15:0] want, input int hold);
    int cyc;
    send(a);
    send(b);
    send(c);
    send(d);
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_latency"}, cyc, 32'd4);
    check({tag, "_sum"}, {16'd0, out_sum}, {16'd0, want});
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_hold_sum"}, {16'd0, out_sum}, {16'd0, want});
      check({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_idle_in_ready"}, {31'd0, in_ready}, 32'd0);
    tick();
    check({tag, "_accept_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k [4];
    int total;
    logic [15:0] w [4];

    rst = 1'b1;
    repeat (3) tick();
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_sum", {16'd0, out_sum}, 32'd0);
    rst = 1'b0;
    check("post_reset_idle", {31'd0, in_ready}, 32'd0);
    tick();
    check("post_reset_accept", {31'd0, in_ready}, 32'd1);

    run_window("ones", 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h4400, 5);
    run_window("mixed", 16'h4000, 16'h3800, 16'hBE00, 16'h3800, 16'h3E00, 0);
    run_window("cancel", 16'h3C00, 16'hBC00, 16'h0000, 16'h0000, 16'h0000, 1);
    run_window("sat_pos", 16'h7BFF, 16'h7BFF, 16'h7BFF, 16'h7BFF, 16'h7BFF, 0);
    run_window("sat_neg", 16'hFBFF, 16'hFBFF, 16'hFBFF, 16'hFBFF,
               Relu ? 16'h0000 : 16'hFBFF, 0);
    run_window("sticky", 16'h7BFF, 16'h7BFF, 16'hFBFF, 16'hFBFF, 16'h7BFF, 0);
    run_window("neg_sum", 16'h3C00, 16'hC200, 16'h0000, 16'h0000,
               Relu ? 16'h0000 : 16'hC000, 2);
    run_window("zero_exp", 16'h3C00, 16'h03FF, 16'h83FF, 16'h3C00, 16'h4000, 0);
    run_window("flush", 16'h0800, 16'h8600, 16'h0000, 16'h0000, 16'h0000, 0);

    // Abort a window with a product in flight; the next window must start from +0.
    send(16'h4400);
    send(16'h4400);
    rst = 1'b1;
    tick();
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_sum", {16'd0, out_sum}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    run_window("after_rst", 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h4400, 0);

    for (int win = 0; win < 12; win++) begin
      total = 0;
      for (int j = 0; j < 4; j++) begin
        k[j]  = int'($urandom_range(128, 0)) - 64;
        w[j]  = enc(k[j]);
        total += k[j];
      end
      run_window($sformatf("rand%0d", win), w[0], w[1], w[2], w[3],
                 (Relu && total < 0) ? 16'h0000 : enc(total), int'($urandom_range(3, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
